fifo_ctrl: RTL and testbench

//   Pointer/flag controller for a synchronous FIFO built around reg_file.

---
 rtl/fifo_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a synchronous FIFO wrapped around
// an external reg_file with one-cycle synchronous read.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wr_i, rd_i            push / pop requests
//   wr_en_o, rd_en_o      accepted push / pop, drive reg_file enables
//   w_addr_o, r_addr_o    reg_file write / read addresses
//   rd_valid_o            reg_file read data holds the popped word this cycle
//   full_o, empty_o       occupancy == depth / occupancy == 0
//   almost_full_o         occupancy >= AlmostFullThr
//   almost_empty_o        occupancy <= AlmostEmptyThr
//   count_o               occupancy, 0..depth
//   overflow_o            pulse: push was rejected last cycle (FIFO full)
//   underflow_o           pulse: pop was rejected last cycle (FIFO empty)
module fifo_ctrl #(
    parameter int AddrBits       = 3,
    parameter int AlmostFullThr  = 6,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                rd_i,
    output logic                wr_en_o,
    output logic                rd_en_o,
    output logic [AddrBits-1:0] w_addr_o,
    output logic [AddrBits-1:0] r_addr_o,
    output logic                rd_valid_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [AddrBits:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam logic [AddrBits:0] AfThr = AlmostFullThr[AddrBits:0];
    localparam logic [AddrBits:0] AeThr = AlmostEmptyThr[AddrBits:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AddrBits:0] wr_ptr_q, wr_ptr_d;
    logic [AddrBits:0] rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full, empty;

    always_comb begin
        full  = (wr_ptr_q[AddrBits] != rd_ptr_q[AddrBits]) &&
                (wr_ptr_q[AddrBits-1:0] == rd_ptr_q[AddrBits-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
    end

    // Enables are also forced low while reset is held, since the pointers
    // alone would still let a push through during reset.
    assign wr_en_o = wr_i & ~full  & ~rst_i;
    assign rd_en_o = rd_i & ~empty & ~rst_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_en_o;
        overflow_d  = wr_i & full;
        underflow_d = rd_i & empty;
        if (wr_en_o) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en_o) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign w_addr_o       = wr_ptr_q[AddrBits-1:0];
    assign r_addr_o       = rd_ptr_q[AddrBits-1:0];
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_o >= AfThr);
    assign almost_empty_o = (count_o <= AeThr);
    assign rd_valid_o     = rd_valid_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       wr_i = 1'b0;
    logic       rd_i = 1'b0;
    logic       wr_en_o, rd_en_o, rd_valid_o;
    logic [2:0] w_addr_o, r_addr_o;
    logic       full_o, empty_o, almost_full_o, almost_empty_o;
    logic [3:0] count_o;
    logic       overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    fifo_ctrl #(.AddrBits(3), .AlmostFullThr(6), .AlmostEmptyThr(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .rd_i(rd_i),
        .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
        .w_addr_o(w_addr_o), .r_addr_o(r_addr_o),
        .rd_valid_o(rd_valid_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // reg_file stand-in: 8 x 8 storage, one-cycle synchronous read
    logic [7:0] wdata = 8'h00;
    logic [7:0] mem [8];
    logic [7:0] rd_data;
    always @(posedge clk_i) begin
        if (wr_en_o) mem[w_addr_o] <= wdata;
        if (rd_en_o) rd_data <= mem[r_addr_o];
    end

    // Reference model: a plain queue with FIFO semantics, capacity 8
    logic [7:0] exp_q[$];
    logic [7:0] exp_rdata = 8'h00;
    bit         exp_valid, exp_ovf, exp_unf;
    int         pushes, pops;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_q.delete();
            exp_valid = 0; exp_ovf = 0; exp_unf = 0;
            pushes = 0; pops = 0;
        end else begin
            int sz;
            sz = exp_q.size();
            exp_ovf   = wr_i && sz == 8;
            exp_unf   = rd_i && sz == 0;
            exp_valid = rd_i && sz > 0;
            if (exp_valid) begin
                exp_rdata = exp_q.pop_front();
                pops++;
            end
            if (wr_i && sz < 8) begin
                exp_q.push_back(wdata);
                pushes++;
            end
        end
    end

    task automatic set_in(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk_i);
        wr_i = w; rd_i = r; wdata = d;
        #1;
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 8'h55);
        adv();
        #2 rst_i = 1'b1;
        #1;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if ({empty_o, full_o, almost_empty_o, almost_full_o} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {empty_o, full_o, almost_empty_o, almost_full_o}); end
        checks++; if ({rd_valid_o, overflow_o, underflow_o} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rd_valid_o, overflow_o, underflow_o}); end
        checks++; if ({wr_en_o, rd_en_o} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b exp 00", {wr_en_o, rd_en_o}); end
        checks++; if ({w_addr_o, r_addr_o} !== 6'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", {w_addr_o, r_addr_o}); end
        set_in(1'b0, 1'b0, 8'h00);
        rst_i = 1'b0;
        adv();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 1'b0, 8'h10 + 8'(i));
            checks++; if (wr_en_o !== (i < 8)) begin errors++; $display("FAIL fill_wr_en[%0d] got %b exp %b", i, wr_en_o, i < 8); end
            adv();
            checks++; if (count_o !== 4'(exp_q.size()) || count_o !== 4'((i < 8) ? i + 1 : 8)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count_o, exp_q.size()); end
            checks++; if (almost_full_o !== (exp_q.size() >= 6) || full_o !== (exp_q.size() == 8)) begin errors++; $display("FAIL fill_flags[%0d] got af=%b f=%b size %0d", i, almost_full_o, full_o, exp_q.size()); end
            checks++; if (overflow_o !== exp_ovf || overflow_o !== (i == 8)) begin errors++; $display("FAIL fill_overflow[%0d] got %b exp %b", i, overflow_o, i == 8); end
        end
        set_in(1'b0, 1'b0, 8'h00);
        adv();
        checks++; if (overflow_o !== 1'b0 || count_o !== 4'd8) begin errors++; $display("FAIL fill_after got ovf=%b count=%0d exp 0/8", overflow_o, count_o); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 9; i++) begin
            set_in(1'b0, 1'b1, 8'h00);
            checks++; if (rd_en_o !== (i < 8)) begin errors++; $display("FAIL drain_rd_en[%0d] got %b exp %b", i, rd_en_o, i < 8); end
            adv();
            checks++; if (rd_valid_o !== (i < 8)) begin errors++; $display("FAIL drain_valid[%0d] got %b exp %b", i, rd_valid_o, i < 8); end
            if (i < 8) begin
                checks++; if (rd_data !== 8'h10 + 8'(i) || rd_data !== exp_rdata) begin errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", i, rd_data, 8'h10 + 8'(i)); end
            end
            checks++; if (underflow_o !== (i == 8)) begin errors++; $display("FAIL drain_underflow[%0d] got %b exp %b", i, underflow_o, i == 8); end
            checks++; if (almost_empty_o !== (exp_q.size() <= 2) || empty_o !== (exp_q.size() == 0)) begin errors++; $display("FAIL drain_flags[%0d] got ae=%b e=%b size %0d", i, almost_empty_o, empty_o, exp_q.size()); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 8'($urandom));
            adv();
        end
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b1, 8'($urandom));
            checks++; if ({wr_en_o, rd_en_o} !== 2'b11) begin errors++; $display("FAIL simul_enables[%0d] got %b exp 11", i, {wr_en_o, rd_en_o}); end
            adv();
            checks++; if (count_o !== 4'd4) begin errors++; $display("FAIL simul_count[%0d] got %0d exp 4", i, count_o); end
            checks++; if (rd_valid_o !== 1'b1 || rd_data !== exp_rdata) begin errors++; $display("FAIL simul_data[%0d] got v=%b %0h exp %0h", i, rd_valid_o, rd_data, exp_rdata); end
            checks++; if (w_addr_o !== 3'(pushes) || r_addr_o !== 3'(pops)) begin errors++; $display("FAIL simul_addr[%0d] got w=%0d r=%0d exp %0d %0d", i, w_addr_o, r_addr_o, pushes % 8, pops % 8); end
        end
    endtask

    task automatic test_edge_simultaneous();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 8'($urandom));
            adv();
        end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL edge_full got %b exp 1", full_o); end
        set_in(1'b1, 1'b1, 8'h99);
        checks++; if ({wr_en_o, rd_en_o} !== 2'b01) begin errors++; $display("FAIL edge_full_en got %b exp 01", {wr_en_o, rd_en_o}); end
        adv();
        checks++; if (count_o !== 4'd7 || overflow_o !== 1'b1 || rd_data !== exp_rdata) begin errors++; $display("FAIL edge_full_res got count=%0d ovf=%b data=%0h exp 7/1/%0h", count_o, overflow_o, rd_data, exp_rdata); end
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 1'b1, 8'h00);
            adv();
        end
        set_in(1'b1, 1'b1, 8'h3C);
        checks++; if ({wr_en_o, rd_en_o} !== 2'b10) begin errors++; $display("FAIL edge_empty_en got %b exp 10", {wr_en_o, rd_en_o}); end
        set_in(1'b0, 1'b0, 8'h00);
        checks++; if (count_o !== 4'd1 || underflow_o !== 1'b1 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL edge_empty_res got count=%0d unf=%b v=%b exp 1/1/0", count_o, underflow_o, rd_valid_o); end
        set_in(1'b0, 1'b1, 8'h00);
        adv();
        checks++; if (rd_valid_o !== 1'b1 || rd_data !== 8'h3C) begin errors++; $display("FAIL edge_empty_read got v=%b %0h exp 1/3c", rd_valid_o, rd_data); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b0, 8'($urandom));
            adv();
        end
        checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d exp 5", count_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (count_o !== 4'd0 || empty_o !== 1'b1 || wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_reset got count=%0d e=%b wen=%b exp 0/1/0", count_o, empty_o, wr_en_o); end
        set_in(1'b1, 1'b0, 8'hAA);
        rst_i = 1'b0;
        adv();
        set_in(1'b0, 1'b1, 8'h00);
        adv();
        checks++; if (rd_valid_o !== 1'b1 || rd_data !== 8'hAA) begin errors++; $display("FAIL mid_read got v=%b %0h exp 1/aa", rd_valid_o, rd_data); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), 1'($urandom), 8'($urandom));
            checks++; if (wr_en_o !== (wr_i && exp_q.size() < 8) || rd_en_o !== (rd_i && exp_q.size() > 0)) begin errors++; $display("FAIL rand_en[%0d] got %b%b size %0d", i, wr_en_o, rd_en_o, exp_q.size()); end
            adv();
            checks++; if (count_o !== 4'(exp_q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d exp %0d", i, count_o, exp_q.size()); end
            checks++; if ({full_o, empty_o, almost_full_o, almost_empty_o} !== {exp_q.size() == 8, exp_q.size() == 0, exp_q.size() >= 6, exp_q.size() <= 2}) begin errors++; $display("FAIL rand_flags[%0d] got %b size %0d", i, {full_o, empty_o, almost_full_o, almost_empty_o}, exp_q.size()); end
            checks++; if ({rd_valid_o, overflow_o, underflow_o} !== {exp_valid, exp_ovf, exp_unf}) begin errors++; $display("FAIL rand_pulses[%0d] got %b exp %b", i, {rd_valid_o, overflow_o, underflow_o}, {exp_valid, exp_ovf, exp_unf}); end
            if (exp_valid) begin
                checks++; if (rd_data !== exp_rdata) begin errors++; $display("FAIL rand_data[%0d] got %0h exp %0h", i, rd_data, exp_rdata); end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        #12 rst_i = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_edge_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
